// File: rtl/bit_vector_adder_pkg.sv
// bit_vector_adder_pkg: shared count-width helper and loop-based reference popcount
//   sum_width(n)        : bits needed to hold 0..n inclusive
//   popcount_ref(v, n)  : ones-count of the low n bits of v (n <= MAX_WIDTH)
package bit_vector_adder_pkg;
  localparam int MAX_WIDTH = 1024;
  function automatic int sum_width(input int n);
    return $clog2(n) + 1;
  endfunction
  function automatic int popcount_ref(input logic [MAX_WIDTH-1:0] v, input int n);
    int acc;
    acc = 0;
    for (int i = 0; i < MAX_WIDTH; i++)
      if (i < n) acc += int'(v[i]);
    return acc;
  endfunction
endpackage

// File: rtl/popcount_tree.sv
// popcount_tree: recursive balanced adder tree counting the set bits of vector
//   vector : WIDTH-bit input
//   sum    : sum_width(WIDTH)-bit ones-count (combinational)
module popcount_tree import bit_vector_adder_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]            vector,
  output logic [sum_width(WIDTH)-1:0] sum
);
  if (WIDTH == 1) begin : g_leaf
    assign sum = vector;
  end else begin : g_split
    localparam int LO = WIDTH / 2;
    localparam int HI = WIDTH - LO;
    localparam int OW = sum_width(WIDTH);
    logic [sum_width(LO)-1:0] lo_sum;
    logic [sum_width(HI)-1:0] hi_sum;
    popcount_tree #(.WIDTH(LO)) u_lo (.vector(vector[LO-1:0]), .sum(lo_sum));
    popcount_tree #(.WIDTH(HI)) u_hi (.vector(vector[WIDTH-1:LO]), .sum(hi_sum));
    // widen both halves first so the carry out of the add is kept
    assign sum = OW'(lo_sum) + OW'(hi_sum);
  end
endmodule

// File: rtl/bit_vector_adder.sv
// bit_vector_adder: registered popcount computed by an adder tree and a loop, cross-checked
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   in_valid      : capture vector this cycle
//   vector        : VECTOR_SIZE-bit input to count
//   out_valid     : sums hold a fresh result
//   sum_recursion : registered count from the adder tree
//   sum_for_loop  : registered count from the loop
//   mismatch      : registered, 1 when the two counts differ
module bit_vector_adder import bit_vector_adder_pkg::*; #(
  parameter  int VECTOR_SIZE = 16,
  localparam int SUM_W       = sum_width(VECTOR_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [VECTOR_SIZE-1:0] vector,
  output logic                   out_valid,
  output logic [SUM_W-1:0]       sum_recursion,
  output logic [SUM_W-1:0]       sum_for_loop,
  output logic                   mismatch
);
  logic [SUM_W-1:0] tree_sum;
  logic [SUM_W-1:0] loop_sum;
  popcount_tree #(.WIDTH(VECTOR_SIZE)) u_tree (.vector(vector), .sum(tree_sum));
  assign loop_sum = SUM_W'(popcount_ref(MAX_WIDTH'(vector), VECTOR_SIZE));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid     <= 1'b0;
      sum_recursion <= '0;
      sum_for_loop  <= '0;
      mismatch      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_recursion <= tree_sum;
        sum_for_loop  <= loop_sum;
        mismatch      <= tree_sum != loop_sum;
      end
    end
endmodule

// File: tb/tb_bit_vector_adder.sv
// tb_bit_vector_adder: scoreboard bench for bit_vector_adder at widths 16, 1, 7 and 33
module tb_bit_vector_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [32:0] r = '0;
  logic [15:0] v16;
  logic [0:0]  v1;
  logic [6:0]  v7;
  assign v16 = r[15:0];
  assign v1  = r[0:0];
  assign v7  = r[6:0];
  logic ov16, ov1, ov7, ov33, mm16, mm1, mm7, mm33;
  logic [4:0] s16r, s16l;
  logic [0:0] s1r, s1l;
  logic [3:0] s7r, s7l;
  logic [6:0] s33r, s33l;
  bit_vector_adder #(.VECTOR_SIZE(16)) dut16 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .vector(v16),
    .out_valid(ov16), .sum_recursion(s16r), .sum_for_loop(s16l), .mismatch(mm16));
  bit_vector_adder #(.VECTOR_SIZE(1)) dut1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .vector(v1),
    .out_valid(ov1), .sum_recursion(s1r), .sum_for_loop(s1l), .mismatch(mm1));
  bit_vector_adder #(.VECTOR_SIZE(7)) dut7 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .vector(v7),
    .out_valid(ov7), .sum_recursion(s7r), .sum_for_loop(s7l), .mismatch(mm7));
  bit_vector_adder #(.VECTOR_SIZE(33)) dut33 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .vector(r),
    .out_valid(ov33), .sum_recursion(s33r), .sum_for_loop(s33l), .mismatch(mm33));
  always #5 clk = ~clk;
  typedef struct {
    logic v;
    int   s16, s1, s7, s33;
  } exp_t;
  typedef struct {
    logic [15:0] vec;
    int          sum;
  } vec_t;
  exp_t q[$];
  exp_t last;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  task automatic chk_dut(input string n, input logic ov, input logic [31:0] sr, input logic [31:0] sl,
                         input logic mm, input logic ev, input int es);
    chk({n, ".out_valid"}, 32'(ov), 32'(ev));
    chk({n, ".sum_recursion"}, sr, es);
    chk({n, ".sum_for_loop"}, sl, es);
    chk({n, ".mismatch"}, 32'(mm), 32'd0);
  endtask
  task automatic chk_all(input exp_t e);
    chk_dut("w16", ov16, 32'(s16r), 32'(s16l), mm16, e.v, e.s16);
    chk_dut("w1", ov1, 32'(s1r), 32'(s1l), mm1, e.v, e.s1);
    chk_dut("w7", ov7, 32'(s7r), 32'(s7l), mm7, e.v, e.s7);
    chk_dut("w33", ov33, 32'(s33r), 32'(s33l), mm33, e.v, e.s33);
  endtask
  task automatic step(input logic v, input logic [32:0] x);
    exp_t e;
    in_valid = v;
    r = x;
    e.v   = v;
    e.s16 = v ? $countones(x[15:0]) : last.s16;
    e.s1  = v ? $countones(x[0:0])  : last.s1;
    e.s7  = v ? $countones(x[6:0])  : last.s7;
    e.s33 = v ? $countones(x)       : last.s33;
    last = e;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard: queue empty");
    end else chk_all(q.pop_front());
  endtask
  task automatic step_exp(input logic [15:0] x, input int want);
    chk("table_model", 32'($countones(x)), 32'(want));
    step(1'b1, {17'd0, x});
  endtask
  initial begin
    vec_t tbl[6];
    exp_t zero;
    zero = '{1'b0, 0, 0, 0, 0};
    tbl = '{'{16'hFFFF, 16}, '{16'h0001, 1}, '{16'h8000, 1},
            '{16'hAAAA, 8}, '{16'h5555, 8}, '{16'h3333, 8}};
    rst_n = 1'b0;
    in_valid = 1'b1;
    r = '1;
    repeat (3) @(posedge clk);
    #1;
    chk_all(zero);
    rst_n = 1'b1;
    last = zero;
    step(1'b1, 33'd0);
    for (int i = 0; i < 6; i++) step_exp(tbl[i].vec, tbl[i].sum);
    step(1'b0, {17'd0, 16'h0F00});
    step(1'b0, {17'd0, 16'h0F00});
    chk("hold_sum16", 32'(s16r), 32'd8);
    step(1'b1, {17'd0, 16'h0F00});
    chk("resume_sum16", 32'(s16l), 32'd4);
    step(1'b1, '1);
    chk("ones_w33", 32'(s33r), 32'd33);
    chk("ones_w16_msb", 32'(s16r[4]), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all(zero);
    #2;
    rst_n = 1'b1;
    q.delete();
    last = zero;
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 3) != 0, {1'($urandom), 32'($urandom)});
    step(1'b1, '1);
    chk("final_ones_w1", 32'(s1r), 32'd1);
    chk("final_ones_w7", 32'(s7l), 32'd7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bit_vector_adder.md
Name: bit_vector_adder

Overview:
- Population-count (ones-count) block: reports how many bits of an input vector are 1.
- Computes the count two independent ways: a recursive balanced adder tree and an iterative accumulate loop.
- Both results are registered and cross-checked every cycle with a mismatch flag.
- Used as a self-checking popcount primitive wherever a set-bit count of a status or mask vector is needed.

Parameters:
- VECTOR_SIZE, 16, input vector width in bits; legal range 1..1024, any value (not restricted to powers of two).
- SUM_W (localparam), $clog2(VECTOR_SIZE)+1, width of each count output; holds 0..VECTOR_SIZE inclusive.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies vector for capture this cycle.
- vector  input  VECTOR_SIZE  bit vector to be counted.
- out_valid  output  1  sum outputs hold a fresh result.
- sum_recursion  output  SUM_W  registered count from the recursive tree.
- sum_for_loop  output  SUM_W  registered count from the loop implementation.
- mismatch  output  1  registered; 1 when the two counts differ.

Behaviour:
- Reset (rst_n low, asynchronous, independent of clk): out_valid=0, sum_recursion=0, sum_for_loop=0, mismatch=0. Outputs stay at these values while rst_n is low.
- Datapath before the output registers is purely combinational. There is no input register.
- Latency is 1 cycle. On a rising edge with in_valid=1:
  - both sums register popcount(vector);
  - mismatch registers (tree != loop);
  - out_valid <= 1.
- On a rising edge with in_valid=0:
  - out_valid <= 0;
  - sum_recursion, sum_for_loop and mismatch hold their previous values.
- No backpressure. A new vector is accepted every cycle in_valid is high (throughput 1/cycle).
- Recursive tree, for width W:
  - W==1 returns the bit zero-extended;
  - otherwise splits into low half floor(W/2) and high half ceil(W/2), counts each recursively, then adds;
  - each level's result width is $clog2(W)+1;
  - operands are zero-extended before the add, so no carry is lost.
- Loop implementation: accumulator of SUM_W bits starts at 0; for i in 0..VECTOR_SIZE-1 it adds vector[i].
- Boundaries:
  - all-zero vector gives 0;
  - all-ones vector gives VECTOR_SIZE, with the MSB of SUM_W set when VECTOR_SIZE is a power of two;
  - VECTOR_SIZE=1 gives SUM_W=1 and count = vector[0].
- Reset asserted mid-stream forces the reset values immediately. The first valid result after rst_n deasserts appears one edge after the first in_valid=1 capture.
- mismatch is a design-integrity flag; in correct RTL it is always 0. It is not sticky.
- X on vector while in_valid=1 is a usage error; the output value is undefined.

Decomposition:
- Package bit_vector_adder_pkg holds:
  - function sum_width(int n) returning $clog2(n)+1;
  - function popcount_ref, a loop-based function that the loop path and the bench share.
- Sub-module popcount_tree #(WIDTH):
  - self-instantiating recursive module using generate on WIDTH==1 vs the split case;
  - output width sum_width(WIDTH);
  - instantiated once in bit_vector_adder for the sum_recursion path.
- Loop path, compare logic and output registers live in bit_vector_adder.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, vector=16'hFFFF, clk toggling -> out_valid=0, both sums 0, mismatch=0. Deassert rst_n and present vector=16'h0000 with in_valid=1 -> next edge both sums 0, out_valid=1.
- Extremes: 16'hFFFF -> both sums 5'd16, mismatch=0. 16'h0001 -> 1. 16'h8000 -> 1.
- Patterns, presented back-to-back at one vector per cycle with in_valid=1 -> results pipelined with 1-cycle latency, mismatch=0 throughout:
  - 16'hAAAA -> 8;
  - 16'h5555 -> 8;
  - 16'h3333 -> 8.
- Hold: drop in_valid after 16'h3333 while changing vector to 16'h0F00 -> out_valid=0, sums stay 8. Raise in_valid -> sums become 4.
- Async reset mid-stream: assert rst_n low between clock edges while out_valid=1 -> outputs go to 0 immediately, without waiting for an edge.
- Sweep: 10k random vectors at VECTOR_SIZE=16, plus VECTOR_SIZE=1, 7 and 33 -> both sums equal popcount_ref; mismatch never 1; all-ones gives 1, 7 and 33 respectively.
